// File: rtl/alu_test_pkg.sv
// ============================================================================
// Module  : alu_test_pkg
// Brief   : Shared constants, FSM state type and MISR step for ALU self-test
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_test_pkg;

    localparam int              MISR_WIDTH = 16;
    localparam logic [15:0]     MISR_POLY  = 16'hB400;
    localparam logic [15:0]     MISR_SEED  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Galois MISR step: shift right, fold the dropped bit through POLY, absorb data.
    function automatic logic [MISR_WIDTH-1:0] misr_step(
        input logic [MISR_WIDTH-1:0] sig,
        input logic [MISR_WIDTH-1:0] data
    );
        logic [MISR_WIDTH-1:0] s;
        s = sig >> 1;
        if (sig[0]) begin
            s = s ^ MISR_POLY;
        end
        return s ^ data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_misr_step.sv
// ============================================================================
// Module  : alu_misr_step
// Brief   : Combinational single step of a Galois MISR
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_misr_step #(
    parameter int               WIDTH = alu_test_pkg::MISR_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = alu_test_pkg::MISR_POLY
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next_sig
);

    logic [WIDTH-1:0] w_shift;

    assign w_shift  = (sig >> 1) ^ (sig[0] ? POLY : '0);
    assign next_sig = w_shift ^ data;

endmodule

`default_nettype wire

// File: rtl/alu_signature_checker.sv
// ============================================================================
// Module  : alu_signature_checker
// Brief   : Compacts N ALU result words into a MISR signature and checks it
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_signature_checker #(
    parameter int               WIDTH = alu_test_pkg::MISR_WIDTH,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] POLY  = alu_test_pkg::MISR_POLY,
    parameter logic [WIDTH-1:0] SEED  = alu_test_pkg::MISR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [WIDTH-1:0] expected_sig,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] sample_count
);

    import alu_test_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_num;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_sig_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_accept;

    alu_misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_step (
        .sig      (r_sig),
        .data     (res_data),
        .next_sig (w_sig_nxt)
    );

    assign w_count_inc = r_count + 1'b1;
    // start takes priority, so a same-cycle result during a restart is dropped
    assign w_accept    = (r_state == CAPTURE) && res_valid && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE, CAPTURE: begin
                if (start) begin
                    w_state_nxt = (num_samples == '0) ? DONE : CAPTURE;
                end else if (w_accept && (w_count_inc == r_num)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state)
            CAPTURE: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (r_sig == r_exp);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig   <= SEED;
            r_count <= '0;
            r_num   <= '0;
            r_exp   <= '0;
        end else if (start) begin
            r_sig   <= SEED;
            r_count <= '0;
            r_num   <= num_samples;
            r_exp   <= expected_sig;
        end else if (w_accept) begin
            r_sig   <= w_sig_nxt;
            r_count <= w_count_inc;
        end
    end

    assign signature    = r_sig;
    assign sample_count = r_count;

endmodule

`default_nettype wire

// File: doc/alu_signature_checker.md
Name: alu_signature_checker

Overview:
- Receiving end of the ALU stimulus path: the operand driver feeds pseudo-random operands into the 16-bit ALU/gate units, and this block compacts the results they return.
- A 16-bit MISR (multiple-input signature register) folds a programmed number of result words into one signature, then compares it against an expected golden value.
- Sits beside the ALU in self-test builds; gives a single pass/fail for long random runs instead of per-vector checking.

Parameters:
- WIDTH, 16, data and signature width.
- CNT_W, 8, width of sample counter and num_samples.
- POLY, 16'hB400, Galois feedback polynomial mask.
- SEED, 16'hFFFF, signature value loaded at reset and at start.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new capture run; sampled on a clk edge
- num_samples  input  CNT_W  result words to compact; latched at start
- expected_sig  input  WIDTH  golden signature; latched at start
- res_valid  input  1  res_data is valid this cycle
- res_data  input  WIDTH  ALU result word
- busy  output  1  high while in CAPTURE
- done  output  1  high while in DONE
- pass  output  1  done && (signature == latched expected)
- signature  output  WIDTH  current MISR contents, registered
- sample_count  output  CNT_W  results accepted in current run, registered

Behaviour:
- Reset (async, any time, including mid-run) puts the block in IDLE:
  - signature=SEED, sample_count=0, latched num/expected=0.
  - busy=0, done=0, pass=0.
- States: IDLE, CAPTURE, DONE. busy = (state==CAPTURE); done = (state==DONE).
- MISR step, combinational:
  - fb = sig[0]
  - s = sig >> 1
  - if fb, then s = s ^ POLY
  - next = s ^ res_data
- IDLE or DONE with start=1 at an edge:
  - signature<=SEED, sample_count<=0.
  - Latch num_samples and expected_sig.
  - If num_samples==0, go to DONE (signature stays SEED); otherwise go to CAPTURE.
- CAPTURE with res_valid=1 at an edge:
  - signature<=next, sample_count<=sample_count+1.
  - If sample_count+1 == latched num, go to DONE on the same edge. done is then high the cycle after the last accepted sample.
- CAPTURE with res_valid=0: hold all registers. Gaps are allowed; there is no timeout.
- start=1 during CAPTURE: restart with the same actions as from IDLE, and any same-cycle res_valid is dropped.
- res_valid outside CAPTURE is ignored.
- DONE holds signature, sample_count and pass until start or reset.
- sample_count never wraps, because capture ends at num_samples ≤ 2^CNT_W−1.
- Latency: first sample accepted no earlier than the cycle after start.

Decomposition:
- Package alu_test_pkg:
  - WIDTH, POLY, SEED constants.
  - State enum (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2).
  - A function or constant for the MISR step, reused by the bench model.
- One sub-module, alu_misr_step: purely combinational (sig, data) -> next signature. It is shared with the stimulus-side LFSR and the golden model.

Test Plan:
- Reset, then start with num_samples=1, expected=16'hCBFF, one res_valid with res_data=16'h0000 -> signature=16'hCBFF, sample_count=1, done=1 and pass=1 one cycle after the sample, busy=0.
- num_samples=2, data 16'h0000 then 16'h0001, with 3 idle cycles between them -> signature goes 16'hCBFF then 16'hD1FE; registers hold during the gap; done only after the second sample.
- num_samples=2, same data, expected=16'h1234 -> done=1, pass=0, signature=16'hD1FE.
- num_samples=0 with start -> DONE on next cycle, signature=16'hFFFF, sample_count=0; pass=1 when expected=16'hFFFF.
- Mid-run events:
  - start re-asserted after one sample -> signature=16'hFFFF, sample_count=0, still CAPTURE; the res_valid in the same cycle is dropped.
  - rst asserted asynchronously between edges -> outputs drop to reset values immediately.
- 200 random vectors, matching the ALU nand_gate stimulus style (num_samples=200), expected value computed by the alu_misr_step reference model -> pass=1. Flipping one bit of one vector -> pass=0.
